// File: rtl/lcd_write_driver.sv
// HD44780-style character LCD write driver: runs the power-up/init sequence,
// then writes one command or data byte per valid/ready handshake with EN pulse timing.
module lcd_write_driver #(
   parameter int P_POWERUP = 750000,
   parameter int P_TSU     = 2,
   parameter int P_TEN     = 25,
   parameter int P_TCMD    = 2500,
   parameter int P_TCLR    = 82000,
   parameter int P_CW      = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_valid,
   input  logic       wr_rs,
   input  logic [7:0] wr_data,
   output logic       ready,
   output logic       init_done,
   output logic       LCD_ON,
   output logic       LCD_RS,
   output logic       LCD_EN,
   output logic       LCD_RW,
   output logic [7:0] LCD_DATA
);

   typedef enum logic [2:0] {
      S_PWRUP,
      S_SETUP,
      S_PULSE,
      S_HOLD,
      S_IDLE
   } state_t;

   localparam logic [P_CW-1:0] C_PWR_LAST = P_CW'(P_POWERUP - 1);
   localparam logic [P_CW-1:0] C_TSU_LAST = P_CW'(P_TSU - 1);
   localparam logic [P_CW-1:0] C_TEN_LAST = P_CW'(P_TEN - 1);
   localparam logic [P_CW-1:0] C_CMD_LAST = P_CW'(P_TCMD - 1);
   localparam logic [P_CW-1:0] C_CLR_LAST = P_CW'(P_TCLR - 1);

   function automatic logic [7:0] init_byte(input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = 8'h38;
         2'd1:    b = 8'h0C;
         2'd2:    b = 8'h01;
         default: b = 8'h06;
      endcase
      return b;
   endfunction

   state_t          state_q, state_d;
   logic [P_CW-1:0] cnt_q, cnt_d;
   logic [1:0]      idx_q, idx_d;
   logic            rs_q, rs_d;
   logic [7:0]      data_q, data_d;
   logic            en_q, en_d;
   logic            ready_q, ready_d;
   logic            done_q, done_d;
   logic            on_q;
   logic            slow_cmd;
   logic [P_CW-1:0] hold_last;

   // Clear and home need the long execution time; everything else uses the short one.
   assign slow_cmd  = !rs_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);
   assign hold_last = slow_cmd ? C_CLR_LAST : C_CMD_LAST;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      idx_d   = idx_q;
      rs_d    = rs_q;
      data_d  = data_q;
      en_d    = 1'b0;
      ready_d = 1'b0;
      done_d  = done_q;
      case (state_q)
         S_PWRUP: begin
            if (cnt_q == C_PWR_LAST) begin
               state_d = S_SETUP;
               cnt_d   = '0;
               idx_d   = 2'd0;
               rs_d    = 1'b0;
               data_d  = init_byte(2'd0);
            end
         end
         S_SETUP: begin
            if (cnt_q == C_TSU_LAST) begin
               state_d = S_PULSE;
               cnt_d   = '0;
               en_d    = 1'b1;
            end
         end
         S_PULSE: begin
            if (cnt_q == C_TEN_LAST) begin
               state_d = S_HOLD;
               cnt_d   = '0;
            end else begin
               en_d = 1'b1;
            end
         end
         S_HOLD: begin
            if (cnt_q == hold_last) begin
               cnt_d = '0;
               if (!done_q && idx_q != 2'd3) begin
                  state_d = S_SETUP;
                  idx_d   = idx_q + 2'd1;
                  rs_d    = 1'b0;
                  data_d  = init_byte(idx_q + 2'd1);
               end else begin
                  state_d = S_IDLE;
                  ready_d = 1'b1;
                  done_d  = 1'b1;
               end
            end
         end
         S_IDLE: begin
            cnt_d   = '0;
            ready_d = 1'b1;
            if (wr_valid && ready_q) begin
               state_d = S_SETUP;
               rs_d    = wr_rs;
               data_d  = wr_data;
               ready_d = 1'b0;
            end
         end
         default: begin
            state_d = S_PWRUP;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_PWRUP;
         cnt_q   <= '0;
         idx_q   <= 2'd0;
         rs_q    <= 1'b0;
         data_q  <= 8'h00;
         en_q    <= 1'b0;
         ready_q <= 1'b0;
         done_q  <= 1'b0;
         on_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         rs_q    <= rs_d;
         data_q  <= data_d;
         en_q    <= en_d;
         ready_q <= ready_d;
         done_q  <= done_d;
         on_q    <= 1'b1;
      end
   end

   assign ready     = ready_q;
   assign init_done = done_q;
   assign LCD_ON    = on_q;
   assign LCD_RS    = rs_q;
   assign LCD_EN    = en_q;
   assign LCD_RW    = 1'b0;
   assign LCD_DATA  = data_q;

endmodule

// File: tb/tb_lcd_write_driver.sv
// Testbench for lcd_write_driver: logs EN pulses, handshakes and ready edges,
// and compares them with a timeline model built from the LCD timing rules.
module tb_lcd_write_driver;

   localparam int P_POWERUP = 10;
   localparam int P_TSU     = 2;
   localparam int P_TEN     = 3;
   localparam int P_TCMD    = 5;
   localparam int P_TCLR    = 20;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       wr_valid = 1'b0;
   logic       wr_rs = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       ready, init_done, LCD_ON, LCD_RS, LCD_EN, LCD_RW;
   logic [7:0] LCD_DATA;

   lcd_write_driver #(
      .P_POWERUP(P_POWERUP), .P_TSU(P_TSU), .P_TEN(P_TEN),
      .P_TCMD(P_TCMD), .P_TCLR(P_TCLR), .P_CW(20)
   ) dut (
      .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_rs(wr_rs), .wr_data(wr_data),
      .ready(ready), .init_done(init_done), .LCD_ON(LCD_ON), .LCD_RS(LCD_RS),
      .LCD_EN(LCD_EN), .LCD_RW(LCD_RW), .LCD_DATA(LCD_DATA)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Observed activity logs
   int         rec_start[$];
   int         rec_width[$];
   logic       rec_rs[$];
   logic [7:0] rec_data[$];
   int         rec_rdy[$];
   int         acc_cyc[$];
   logic       acc_rs[$];
   logic [7:0] acc_data[$];
   int         glitches = 0;
   int         rw_hits = 0;
   int         cur_w = 0;
   logic       prev_en = 1'b0, prev_rdy = 1'b0, lat_rs = 1'b0;
   logic [7:0] lat_data = 8'h00;

   // Expected pulse timeline
   int         exp_start[$];
   logic       exp_rs[$];
   logic [7:0] exp_data[$];
   logic [7:0] init_seq [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

   always @(posedge clk) begin
      if (!reset && ready && wr_valid) begin
         acc_cyc.push_back(cyc + 1);
         acc_rs.push_back(wr_rs);
         acc_data.push_back(wr_data);
      end
      cyc <= reset ? 0 : cyc + 1;
   end

   always @(negedge clk) begin
      prev_en  <= LCD_EN;
      prev_rdy <= ready;
      if (LCD_RW !== 1'b0) rw_hits <= rw_hits + 1;
      if (ready && !prev_rdy) rec_rdy.push_back(cyc);
      if (LCD_EN && !prev_en) begin
         rec_start.push_back(cyc);
         rec_rs.push_back(LCD_RS);
         rec_data.push_back(LCD_DATA);
         lat_rs   <= LCD_RS;
         lat_data <= LCD_DATA;
         cur_w    <= 1;
      end else if (LCD_EN) begin
         cur_w <= cur_w + 1;
         if (LCD_RS !== lat_rs || LCD_DATA !== lat_data) glitches <= glitches + 1;
      end else if (prev_en) begin
         rec_width.push_back(cur_w);
      end
   end

   function automatic int hold_of(input logic rs, input logic [7:0] d);
      return (!rs && d >= 8'h01 && d <= 8'h03) ? P_TCLR : P_TCMD;
   endfunction

   // A byte whose SETUP starts at cycle base pulses at base+TSU; returns when ready comes back.
   function automatic int model_byte(input int base, input logic rs, input logic [7:0] d);
      exp_start.push_back(base + P_TSU);
      exp_rs.push_back(rs);
      exp_data.push_back(d);
      return base + P_TSU + P_TEN + hold_of(rs, d);
   endfunction

   function automatic int model_init();
      int t = P_POWERUP;
      for (int i = 0; i < 4; i++) t = model_byte(t, 1'b0, init_seq[i]);
      return t;
   endfunction

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_ready(input int budget, input string tag);
      int n = 0;
      while (ready !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      checks++;
      if (ready !== 1'b1) begin
         errors++;
         $display("FAIL %s_timeout: ready=%b after %0d cycles, required 1", tag, ready, budget);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      wr_valid = 1'b0;
      repeat (3) tick();
      checks++;
      if ({ready, init_done, LCD_ON, LCD_RS, LCD_EN, LCD_RW, LCD_DATA} !== 14'h0) begin
         errors++;
         $display("FAIL reset_outputs: rdy=%b done=%b on=%b rs=%b en=%b rw=%b data=%02h, required all 0",
                  ready, init_done, LCD_ON, LCD_RS, LCD_EN, LCD_RW, LCD_DATA);
      end
   endtask

   task automatic test_init();
      int rb = rec_start.size();
      int rr = rec_rdy.size();
      int n = 0, early = 0, end_c;
      reset = 1'b0;
      tick();
      checks++;
      if (LCD_ON !== 1'b1 || cyc !== 1) begin
         errors++;
         $display("FAIL lcd_on_first_cycle: on=%b cyc=%0d, required on=1 cyc=1", LCD_ON, cyc);
      end
      while (ready !== 1'b1 && n < 200) begin
         if (init_done) early++;
         tick();
         n++;
      end
      exp_start.delete(); exp_rs.delete(); exp_data.delete();
      end_c = model_init();
      checks++;
      if (rec_rdy.size() <= rr || rec_rdy[rr] !== end_c || init_done !== 1'b1 || early != 0) begin
         errors++;
         $display("FAIL init_ready_time: ready_rises=%0d first=%0d done=%b early=%0d, required first=%0d done=1 early=0",
                  rec_rdy.size() - rr, (rec_rdy.size() > rr) ? rec_rdy[rr] : -1, init_done, early, end_c);
      end
      checks++;
      if (rec_start.size() - rb != exp_start.size()) begin
         errors++;
         $display("FAIL init_pulse_count: got %0d, required %0d", rec_start.size() - rb, exp_start.size());
      end
      for (int i = 0; i < exp_start.size() && rb + i < rec_width.size(); i++) begin
         checks++;
         if (rec_start[rb+i] !== exp_start[i] || rec_width[rb+i] !== P_TEN ||
             rec_rs[rb+i] !== exp_rs[i] || rec_data[rb+i] !== exp_data[i]) begin
            errors++;
            $display("FAIL init_pulse%0d: start=%0d w=%0d rs=%b data=%02h, required start=%0d w=%0d rs=%b data=%02h",
                     i, rec_start[rb+i], rec_width[rb+i], rec_rs[rb+i], rec_data[rb+i],
                     exp_start[i], P_TEN, exp_rs[i], exp_data[i]);
         end
      end
   endtask

   task automatic test_writes();
      logic       t_rs  [12];
      logic [7:0] t_dat [12];
      int         t_rec [12];
      int rb = rec_start.size();
      int a, na;
      t_rs[0] = 1'b1; t_dat[0] = 8'h41; t_rec[0] = 10;
      t_rs[1] = 1'b0; t_dat[1] = 8'h01; t_rec[1] = 25;
      t_rs[2] = 1'b0; t_dat[2] = 8'h02; t_rec[2] = 25;
      t_rs[3] = 1'b0; t_dat[3] = 8'h80; t_rec[3] = 10;
      for (int i = 4; i < 12; i++) begin
         t_rs[i]  = 1'($urandom_range(0, 1));
         t_dat[i] = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom_range(0, 255));
         t_rec[i] = P_TSU + P_TEN + hold_of(t_rs[i], t_dat[i]);
      end
      exp_start.delete(); exp_rs.delete(); exp_data.delete();
      for (int i = 0; i < 12; i++) begin
         na = acc_cyc.size();
         wr_valid = 1'b1; wr_rs = t_rs[i]; wr_data = t_dat[i];
         tick();
         wr_valid = 1'b0;
         wr_data = ~t_dat[i];
         checks++;
         if (acc_cyc.size() != na + 1 || ready !== 1'b0 || LCD_RS !== t_rs[i] ||
             LCD_DATA !== t_dat[i] || LCD_EN !== 1'b0) begin
            errors++;
            $display("FAIL write%0d_accept: accepts=%0d rdy=%b rs=%b data=%02h en=%b, required accepts=1 rdy=0 rs=%b data=%02h en=0",
                     i, acc_cyc.size() - na, ready, LCD_RS, LCD_DATA, LCD_EN, t_rs[i], t_dat[i]);
         end
         a = cyc;
         wait_ready(60, "write");
         checks++;
         if (rec_rdy[$] - a !== t_rec[i]) begin
            errors++;
            $display("FAIL write%0d_recovery: ready after %0d cycles, required %0d", i, rec_rdy[$] - a, t_rec[i]);
         end
         $display("write rs=%b data=%02h accepted at %0d, ready after %0d", t_rs[i], t_dat[i], a, rec_rdy[$] - a);
         void'(model_byte(a, t_rs[i], t_dat[i]));
      end
      checks++;
      if (rec_start.size() - rb != exp_start.size()) begin
         errors++;
         $display("FAIL write_pulse_count: got %0d, required %0d", rec_start.size() - rb, exp_start.size());
      end
      for (int i = 0; i < exp_start.size() && rb + i < rec_width.size(); i++) begin
         checks++;
         if (rec_start[rb+i] !== exp_start[i] || rec_width[rb+i] !== P_TEN ||
             rec_rs[rb+i] !== exp_rs[i] || rec_data[rb+i] !== exp_data[i]) begin
            errors++;
            $display("FAIL write_pulse%0d: start=%0d w=%0d rs=%b data=%02h, required start=%0d w=%0d rs=%b data=%02h",
                     i, rec_start[rb+i], rec_width[rb+i], rec_rs[rb+i], rec_data[rb+i],
                     exp_start[i], P_TEN, exp_rs[i], exp_data[i]);
         end
      end
   endtask

   task automatic test_busy_ignore();
      int rb, ab, n = 0, e1, e2;
      reset = 1'b1;
      repeat (2) tick();
      rb = rec_start.size();
      ab = acc_cyc.size();
      reset = 1'b0;
      wr_valid = 1'b1;
      while (acc_cyc.size() - ab < 2 && n < 300) begin
         wr_rs   = 1'($urandom_range(0, 1));
         wr_data = 8'($urandom_range(0, 255));
         tick();
         n++;
      end
      wr_valid = 1'b0;
      wait_ready(60, "busy");
      exp_start.delete(); exp_rs.delete(); exp_data.delete();
      e1 = model_init();
      checks++;
      if (acc_cyc.size() - ab != 2 || acc_cyc[ab] !== e1 + 1) begin
         errors++;
         $display("FAIL busy_first_accept: accepts=%0d first=%0d, required 2 and %0d",
                  acc_cyc.size() - ab, (acc_cyc.size() > ab) ? acc_cyc[ab] : -1, e1 + 1);
      end else begin
         e2 = model_byte(acc_cyc[ab], acc_rs[ab], acc_data[ab]);
         checks++;
         if (acc_cyc[ab+1] !== e2 + 1) begin
            errors++;
            $display("FAIL busy_second_accept: at %0d, required %0d", acc_cyc[ab+1], e2 + 1);
         end
         void'(model_byte(acc_cyc[ab+1], acc_rs[ab+1], acc_data[ab+1]));
      end
      checks++;
      if (rec_start.size() - rb != exp_start.size()) begin
         errors++;
         $display("FAIL busy_pulse_count: got %0d, required %0d", rec_start.size() - rb, exp_start.size());
      end
      for (int i = 0; i < exp_start.size() && rb + i < rec_width.size(); i++) begin
         checks++;
         if (rec_start[rb+i] !== exp_start[i] || rec_width[rb+i] !== P_TEN ||
             rec_rs[rb+i] !== exp_rs[i] || rec_data[rb+i] !== exp_data[i]) begin
            errors++;
            $display("FAIL busy_pulse%0d: start=%0d w=%0d rs=%b data=%02h, required start=%0d w=%0d rs=%b data=%02h",
                     i, rec_start[rb+i], rec_width[rb+i], rec_rs[rb+i], rec_data[rb+i],
                     exp_start[i], P_TEN, exp_rs[i], exp_data[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int rb = rec_start.size();
      int ab = acc_cyc.size();
      int n = 0, gap;
      wr_valid = 1'b1; wr_rs = 1'b1; wr_data = 8'h48;
      while (acc_cyc.size() - ab < 1 && n < 5) begin tick(); n++; end
      wr_data = 8'h49;
      n = 0;
      while (acc_cyc.size() - ab < 2 && n < 50) begin tick(); n++; end
      wr_valid = 1'b0;
      wait_ready(60, "b2b");
      checks++;
      if (acc_cyc.size() - ab != 2 || rec_start.size() - rb != 2) begin
         errors++;
         $display("FAIL b2b_counts: accepts=%0d pulses=%0d, required 2 and 2",
                  acc_cyc.size() - ab, rec_start.size() - rb);
      end else begin
         checks++;
         if (acc_cyc[ab+1] - acc_cyc[ab] !== P_TSU + P_TEN + P_TCMD + 1 ||
             acc_data[ab] !== 8'h48 || acc_data[ab+1] !== 8'h49) begin
            errors++;
            $display("FAIL b2b_accept: spacing=%0d data=%02h,%02h, required %0d and 48,49",
                     acc_cyc[ab+1] - acc_cyc[ab], acc_data[ab], acc_data[ab+1], P_TSU + P_TEN + P_TCMD + 1);
         end
         gap = rec_start[rb+1] - rec_start[rb] - P_TEN;
         checks++;
         if (gap < P_TCMD + P_TSU || rec_data[rb] !== 8'h48 || rec_data[rb+1] !== 8'h49) begin
            errors++;
            $display("FAIL b2b_pulses: gap=%0d data=%02h,%02h, required gap>=%0d data 48,49",
                     gap, rec_data[rb], rec_data[rb+1], P_TCMD + P_TSU);
         end
      end
   endtask

   task automatic test_reset_mid();
      int rb, rr, n = 0, e;
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      rb = rec_start.size();
      while (rec_start.size() - rb < 2 && n < 100) begin tick(); n++; end
      checks++;
      if (LCD_EN !== 1'b1 || LCD_DATA !== 8'h0C) begin
         errors++;
         $display("FAIL mid_pre_reset: en=%b data=%02h, required en=1 data=0C", LCD_EN, LCD_DATA);
      end
      reset = 1'b1;
      tick();
      checks++;
      if ({LCD_EN, LCD_ON, ready, init_done, LCD_RS, LCD_DATA} !== 13'h0) begin
         errors++;
         $display("FAIL mid_reset_outputs: en=%b on=%b rdy=%b done=%b rs=%b data=%02h, required all 0",
                  LCD_EN, LCD_ON, ready, init_done, LCD_RS, LCD_DATA);
      end
      rb = rec_start.size();
      rr = rec_rdy.size();
      reset = 1'b0;
      wait_ready(200, "mid_init");
      exp_start.delete(); exp_rs.delete(); exp_data.delete();
      e = model_init();
      checks++;
      if (rec_rdy.size() <= rr || rec_rdy[$] !== e || rec_start.size() - rb != 4) begin
         errors++;
         $display("FAIL mid_reinit: ready at %0d pulses=%0d, required ready at %0d pulses=4",
                  (rec_rdy.size() > rr) ? rec_rdy[$] : -1, rec_start.size() - rb, e);
      end
      for (int i = 0; i < exp_start.size() && rb + i < rec_width.size(); i++) begin
         checks++;
         if (rec_start[rb+i] !== exp_start[i] || rec_width[rb+i] !== P_TEN || rec_data[rb+i] !== exp_data[i]) begin
            errors++;
            $display("FAIL mid_pulse%0d: start=%0d w=%0d data=%02h, required start=%0d w=%0d data=%02h",
                     i, rec_start[rb+i], rec_width[rb+i], rec_data[rb+i], exp_start[i], P_TEN, exp_data[i]);
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_init();
      test_writes();
      test_busy_ignore();
      test_back_to_back();
      test_reset_mid();
      checks++;
      if (glitches != 0 || rw_hits != 0) begin
         errors++;
         $display("FAIL pin_stability: rs/data changes during EN=%0d, rw high samples=%0d, required 0 and 0",
                  glitches, rw_hits);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lcd_write_driver.md
Name: lcd_write_driver

Overview:
- Sequential HD44780-style character-LCD driver that generates the LCD_ON/RS/EN/RW/DATA pin signals passed to the board by the output wrapper.
- After reset it runs the fixed power-up and init sequence on its own.
- It then accepts one command or data byte at a time from upstream logic over a valid/ready handshake and produces the enable-pulse timing for each byte.
- Write-only: no busy-flag readback.

Parameters:
- P_POWERUP, 750000: idle cycles after reset before the first init write (15 ms at 50 MHz).
- P_TSU, 2: cycles RS/DATA are stable before EN rises.
- P_TEN, 25: cycles EN is held high.
- P_TCMD, 2500: cycles after EN falls for a normal command or data byte (50 us).
- P_TCLR, 82000: cycles after EN falls for clear (0x01) or home (0x02, 0x03) with RS=0 (1.64 ms).
- P_CW, 20: width of the timing counter. Must hold the largest of the values above.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- wr_valid  input  1  upstream has a byte to write
- wr_rs  input  1  0 = command, 1 = character data
- wr_data  input  8  byte to write
- ready  output  1  driver idle; byte accepted when wr_valid && ready at a rising edge
- init_done  output  1  init sequence complete; sticky until reset
- LCD_ON  output  1  panel power/backlight enable
- LCD_RS  output  1  register select to panel
- LCD_EN  output  1  enable strobe to panel
- LCD_RW  output  1  read/write select, constant 0 (write only)
- LCD_DATA  output  8  data bus to panel

Behaviour:
- Clocking: one clock (clk). Reset is synchronous and active-high. All outputs are registered.
- Reset values: ready=0, init_done=0, LCD_ON=0, LCD_RS=0, LCD_EN=0, LCD_RW=0, LCD_DATA=0x00. State=PWRUP, counter=0, init index=0.
- LCD_ON rises on the first edge after reset deasserts and stays 1. LCD_RW is 0 at all times.
- FSM states: PWRUP, SETUP, PULSE, HOLD, IDLE.
- PWRUP: counts P_POWERUP cycles with all pins at reset values. Then loads init byte 0 and enters SETUP.
- Init bytes, all with RS=0, in order: 0x38 (8-bit, 2-line, 5x8), 0x0C (display on, cursor off), 0x01 (clear), 0x06 (entry increment).
- SETUP: LCD_RS/LCD_DATA show the current byte, EN=0, for P_TSU cycles, then go to PULSE.
- PULSE: EN=1 for exactly P_TEN cycles. RS/DATA are unchanged. Then go to HOLD.
- HOLD: EN=0, RS/DATA held. Hold time is P_TCLR cycles if RS=0 and byte is 0x01, 0x02 or 0x03; otherwise P_TCMD cycles.
- After HOLD: if init bytes remain, load the next one and go to SETUP. Otherwise go to IDLE.
- init_done and ready rise together on entry to IDLE after the 4th init byte.
- IDLE: ready=1. RS/DATA keep the last written values. EN=0.
- Handshake: on an edge with wr_valid && ready, wr_rs/wr_data are captured. On the next cycle ready=0 and SETUP starts with the new byte on the pins.
- A write occupies P_TSU+P_TEN+hold cycles. ready reasserts on the cycle after HOLD ends.
- wr_valid while ready=0 (during init or an in-flight write) is ignored. Nothing is queued, and the upstream must keep the byte held.
- EN never pulses outside PULSE. RS/DATA never change while EN=1 or during HOLD.
- Reset mid-operation (any state) returns every output to its reset value on that edge. Any in-flight EN pulse is cut short. The full PWRUP and init sequence reruns.
- Counter: counts 0..N-1 per phase. It clears on every state change, with no wrap.

Test Plan (P_POWERUP=10, P_TSU=2, P_TEN=3, P_TCMD=5, P_TCLR=20):
- Reset release, wr_valid=0 -> exactly 4 EN pulses, each 3 cycles, with DATA 0x38, 0x0C, 0x01, 0x06 and RS=0. The gap after 0x01 is 20 cycles, others 5. ready and init_done first go 1 exactly 65 cycles after reset deasserts. LCD_ON=1 from cycle 1.
- After init, wr_valid=1, wr_rs=1, wr_data=0x41 for one accepted cycle -> ready=0 next cycle. RS=1, DATA=0x41 for 2 cycles before EN. EN high 3 cycles. ready=1 again 10 cycles after acceptance.
- Command write rs=0, data=0x01 -> hold of 20 cycles, ready back after 25 cycles. Repeat with 0x02: same. Repeat with 0x80: 10 cycles.
- wr_valid held high during init and during a write with changing wr_data -> only the byte present on the accepting edge is written. No extra EN pulses.
- Back-to-back writes, wr_valid held continuously with 0x48 then 0x49 -> second accepted on the first ready=1 edge. Pulses separated by at least P_TCMD+P_TSU cycles.
- reset asserted while EN=1 in the 2nd init write -> EN, LCD_ON, ready and init_done go 0 on that edge. After release the full 65-cycle init repeats starting with 0x38.
